// File: rtl/tick_scheduler.sv
// tick_scheduler
// Game-speed tick generator for a tap/rhythm game. A 28-bit down-counter
// produces a one-cycle TICK every LOADn+1 clocks, where n is the current
// speed level. Every HITS_PER_LEVEL successful taps raise the level (up to 3),
// which shortens the tick period starting at the next reload.
//
// Ports
//   CLOCK_50   in   system clock, all state changes on its rising edge
//   RESET      in   asynchronous active-low reset
//   START      in   begin a game (only looked at while idle)
//   PAUSE      in   level, high freezes the game
//   HIT        in   one-cycle pulse per successful tap
//   GAME_OVER  in   end the game and return to idle
//   TICK       out  registered one-cycle game-advance pulse
//   LEVEL      out  current speed level 0..3
//   LEVEL_UP   out  registered one-cycle pulse when LEVEL increments
//   STATE      out  00 idle, 01 running, 10 paused
module tick_scheduler #(
  parameter logic [27:0] LOAD0          = 28'd49_999_999,
  parameter logic [27:0] LOAD1          = 28'd24_999_999,
  parameter logic [27:0] LOAD2          = 28'd12_499_999,
  parameter logic [27:0] LOAD3          = 28'd6_249_999,
  parameter int          HITS_PER_LEVEL = 8
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       HIT,
  input  logic       GAME_OVER,
  output logic       TICK,
  output logic [1:0] LEVEL,
  output logic       LEVEL_UP,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10
  } state_t;

  localparam logic [7:0] HC_LAST = 8'(HITS_PER_LEVEL - 1);

  state_t      r_state, w_stateNext;
  logic [27:0] r_cnt, w_cntNext, w_load;
  logic [7:0]  r_hc, w_hcNext;
  logic [1:0]  r_level, w_levelNext;
  logic        r_tick, w_tickNext;
  logic        r_levelUp, w_levelUpNext;

  // Reload value for the level currently in force. Because this reads the
  // registered level, a hit landing on the same edge as a reload still
  // reloads with the old level's period.
  always_comb begin
    w_load = LOAD0;
    case (r_level)
      2'd0:    w_load = LOAD0;
      2'd1:    w_load = LOAD1;
      2'd2:    w_load = LOAD2;
      default: w_load = LOAD3;
    endcase
  end

  // All state lives here; everything is cleared the moment RESET goes low,
  // so an aborted game always lands back in idle waiting for START.
  always_ff @(posedge CLOCK_50 or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_hc      <= '0;
      r_level   <= '0;
      r_tick    <= 1'b0;
      r_levelUp <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_hc      <= w_hcNext;
      r_level   <= w_levelNext;
      r_tick    <= w_tickNext;
      r_levelUp <= w_levelUpNext;
    end
  end

  // Next-state logic. Counters hold and pulses drop by default; GAME_OVER
  // beats PAUSE, which beats hit processing and counting. In idle, START
  // always wins entry to running even if PAUSE is also high: the pause is
  // honoured one edge later from the running state.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_hcNext      = r_hc;
    w_levelNext   = r_level;
    w_tickNext    = 1'b0;
    w_levelUpNext = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_stateNext = S_RUN;
          w_cntNext   = LOAD0;
          w_hcNext    = '0;
          w_levelNext = 2'd0;
        end
      end

      S_RUN: begin
        if (GAME_OVER) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end else if (PAUSE) begin
          w_stateNext = S_PAUSED;
        end else begin
          if (r_cnt == 28'd0) begin
            w_cntNext  = w_load;
            w_tickNext = 1'b1;
          end else begin
            w_cntNext = r_cnt - 28'd1;
          end

          // At level 3 the hit counter keeps wrapping but the level saturates.
          if (HIT) begin
            if (r_hc == HC_LAST) begin
              w_hcNext = '0;
              if (r_level != 2'd3) begin
                w_levelNext   = r_level + 2'd1;
                w_levelUpNext = 1'b1;
              end
            end else begin
              w_hcNext = r_hc + 8'd1;
            end
          end
        end
      end

      S_PAUSED: begin
        if (GAME_OVER) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end else if (!PAUSE) begin
          w_stateNext = S_RUN;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign TICK     = r_tick;
  assign LEVEL    = r_level;
  assign LEVEL_UP = r_levelUp;
  assign STATE    = r_state;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler
// Self-checking bench for tick_scheduler with small reload values so that
// periods are a few cycles long. A behavioural game model (cycles left in the
// current period, total hits since START) predicts every output each cycle.
module tb_tick_scheduler;

  localparam int HPL = 2;

  logic       clk50 = 1'b0;
  logic       resetN, start, pause, hit, gameOver;
  logic       tick, levelUp;
  logic [1:0] level, state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         loadTab [4] = '{3, 2, 1, 0};
  logic [1:0] mState;
  int         mLeft, mHits, mLevel;
  logic       mTick, mLevelUp;

  logic [5:0] got, exp;

  tick_scheduler #(
    .LOAD0(28'd3), .LOAD1(28'd2), .LOAD2(28'd1), .LOAD3(28'd0),
    .HITS_PER_LEVEL(HPL)
  ) dut (
    .CLOCK_50 (clk50),
    .RESET    (resetN),
    .START    (start),
    .PAUSE    (pause),
    .HIT      (hit),
    .GAME_OVER(gameOver),
    .TICK     (tick),
    .LEVEL    (level),
    .LEVEL_UP (levelUp),
    .STATE    (state)
  );

  always #10 clk50 = ~clk50;

  task automatic modelReset();
    mState = 2'd0; mLeft = 0; mHits = 0; mLevel = 0; mTick = 1'b0; mLevelUp = 1'b0;
  endtask

  // One clock edge of the game: a period is LOADn+1 running cycles, the level
  // is simply total hits / HPL capped at 3, and a reload uses the level that
  // was in force before this edge's hit.
  task automatic modelStep(input logic s, input logic p, input logic h, input logic g);
    int newLevel;
    int reloadLevel;
    mTick = 1'b0;
    mLevelUp = 1'b0;
    case (mState)
      2'd0: if (s) begin
        mState = 2'd1; mLeft = loadTab[0] + 1; mHits = 0; mLevel = 0;
      end
      2'd1: begin
        if (g) mState = 2'd0;
        else if (p) mState = 2'd2;
        else begin
          reloadLevel = mLevel;
          if (h) begin
            mHits++;
            newLevel = (mHits / HPL > 3) ? 3 : mHits / HPL;
            if (newLevel != mLevel) begin
              mLevel = newLevel;
              mLevelUp = 1'b1;
            end
          end
          mLeft--;
          if (mLeft == 0) begin
            mTick = 1'b1;
            mLeft = loadTab[reloadLevel] + 1;
          end
        end
      end
      2'd2: begin
        if (g) mState = 2'd0;
        else if (!p) mState = 2'd1;
      end
      default: mState = 2'd0;
    endcase
  endtask

  // Drive one cycle of inputs, advance the model on the edge, sample just after.
  task automatic applyStimulus(input logic s, input logic p, input logic h, input logic g);
    start = s; pause = p; hit = h; gameOver = g;
    @(posedge clk50);
    modelStep(s, p, h, g);
    #1;
    got = {state, level, tick, levelUp};
    exp = {mState, 2'(mLevel), mTick, mLevelUp};
  endtask

  task automatic test_reset();
    resetN = 1'b0; start = 0; pause = 0; hit = 0; gameOver = 0;
    modelReset();
    #45;
    checks++;
    if ({state, level, tick, levelUp} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %b expected %b", {state, level, tick, levelUp}, 6'b0);
    end
    @(negedge clk50);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL idle_ignore cyc %0d: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_first_tick();
    int firstTick = -1;
    int tickCount = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL start_edge: got %b expected %b", got, exp);
    end
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL first_tick cyc %0d: got %b expected %b", k, got, exp);
      end
      if (tick) begin
        tickCount++;
        if (firstTick < 0) firstTick = k;
      end
    end
    checks++;
    if (firstTick != 4 || tickCount != 3) begin
      errors++;
      $display("[TB] FAIL first_tick_timing: got first=%0d count=%0d expected first=4 count=3", firstTick, tickCount);
    end
  endtask

  task automatic test_level_up();
    int ups = 0;
    int tickAt[$];
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, (k < 2) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL level_up cyc %0d: got %b expected %b", k, got, exp);
      end
      if (levelUp) ups++;
      if (tick) tickAt.push_back(k);
    end
    checks++;
    if (level !== 2'd1 || ups != 1 || tickAt.size() < 3 ||
        tickAt[tickAt.size()-1] - tickAt[tickAt.size()-2] != 3) begin
      errors++;
      $display("[TB] FAIL level_up_period: got level=%0d ups=%0d ticks=%0d expected level=1 ups=1 gap=3",
               level, ups, tickAt.size());
    end
  endtask

  task automatic test_saturation();
    int ups = 0;
    int ticks = 0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, 1'b0, (k < 8) ? 1'b1 : 1'b0, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL saturation cyc %0d: got %b expected %b", k, got, exp);
      end
      if (levelUp) ups++;
      if (k >= 8 && tick) ticks++;
    end
    checks++;
    if (level !== 2'd3 || ups != 3 || ticks != 6) begin
      errors++;
      $display("[TB] FAIL saturation_result: got level=%0d ups=%0d ticks=%0d expected level=3 ups=3 ticks=6",
               level, ups, ticks);
    end
  endtask

  task automatic test_pause();
    int pausedTicks = 0;
    int resumeTick = -1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL pause cyc %0d: got %b expected %b", k, got, exp);
      end
      if (tick) pausedTicks++;
    end
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL pause_resume cyc %0d: got %b expected %b", k, got, exp);
      end
      if (tick && resumeTick < 0) resumeTick = k;
    end
    checks++;
    if (pausedTicks != 0 || resumeTick != 3 || level !== 2'd0) begin
      errors++;
      $display("[TB] FAIL pause_result: got pausedTicks=%0d resume=%0d level=%0d expected 0 3 0",
               pausedTicks, resumeTick, level);
    end
  endtask

  task automatic test_game_over();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (got !== exp || {state, level, tick} !== {2'b00, 2'd1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL game_over: got %b expected %b", got, exp);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp || {state, level} !== {2'b01, 2'd0}) begin
      errors++;
      $display("[TB] FAIL restart_with_pause: got %b expected %b", got, exp);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (got !== exp || state !== 2'b10) begin
      errors++;
      $display("[TB] FAIL pause_after_start: got %b expected %b", got, exp);
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    #4;
    resetN = 1'b0;
    #1;
    modelReset();
    checks++;
    if ({state, level, tick, levelUp} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %b expected %b", {state, level, tick, levelUp}, 6'b0);
    end
    @(negedge clk50);
    resetN = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL wait_for_start cyc %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic p = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) p = ~p;
      applyStimulus($urandom_range(0, 7) == 0, p, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 39) == 0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL random cyc %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_level_up();
    test_saturation();
    test_pause();
    test_game_over();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter LOAD0, default 28'd49_999_999, reload value at level 0 (1 Hz at 50 MHz).
REQ-002 The block SHALL have parameter LOAD1, default 28'd24_999_999, reload value at level 1.
REQ-003 The block SHALL have parameter LOAD2, default 28'd12_499_999, reload value at level 2.
REQ-004 The block SHALL have parameter LOAD3, default 28'd6_249_999, reload value at level 3.
REQ-005 The block SHALL have parameter HITS_PER_LEVEL, default 8, range 1..255, hits needed per level-up.
REQ-006 The block SHALL have port CLOCK_50  input  1  system clock; all state SHALL change on its rising edge.
REQ-007 The block SHALL have port RESET  input  1  reset, asynchronous, active-low.
REQ-008 The block SHALL have port START  input  1  begin game; sampled only in IDLE.
REQ-009 The block SHALL have port PAUSE  input  1  level; high freezes the game.
REQ-010 The block SHALL have port HIT  input  1  one-cycle pulse per successful tap.
REQ-011 The block SHALL have port GAME_OVER  input  1  terminate game.
REQ-012 The block SHALL have port TICK  output  1  registered one-cycle game-advance pulse.
REQ-013 The block SHALL have port LEVEL  output  2  current speed level 0..3.
REQ-014 The block SHALL have port LEVEL_UP  output  1  registered one-cycle pulse on level increment.
REQ-015 The block SHALL have port STATE  output  2  state: 00 IDLE, 01 RUN, 10 PAUSED.

Function
REQ-016 The block SHALL contain a 28-bit down-counter CNT and an 8-bit hit counter HC.
REQ-017 In IDLE, a START edge SHALL set CNT<=LOAD0, LEVEL<=0, HC<=0 and STATE<=RUN.
REQ-018 In RUN, each edge with CNT!=0 SHALL set CNT<=CNT-1 and TICK<=0.
REQ-019 In RUN, each edge with CNT==0 SHALL set CNT<=LOADn for the current LEVEL n and TICK<=1.
REQ-020 The first TICK after START SHALL be high for exactly one cycle, beginning LOAD0+1 edges after the START edge; the steady period SHALL be LOADn+1 cycles.
REQ-021 With LOADn==0, TICK SHALL be high every RUN cycle.
REQ-022 In RUN, a HIT with HC<HITS_PER_LEVEL-1 SHALL increment HC.
REQ-023 In RUN, a HIT with HC==HITS_PER_LEVEL-1 SHALL clear HC; if LEVEL<3 it SHALL increment LEVEL and pulse LEVEL_UP for one cycle.
REQ-024 At LEVEL==3, HITs SHALL wrap HC with no LEVEL change and no LEVEL_UP (saturation).
REQ-025 A new LEVEL SHALL take effect at the next reload; the period in progress SHALL NOT be truncated.
REQ-026 HIT and CNT==0 on the same edge SHALL both be processed; the reload SHALL use the pre-increment LEVEL.
REQ-027 In RUN, PAUSE high SHALL move to PAUSED on that edge, with CNT not decremented and TICK<=0.
REQ-028 In PAUSED, CNT, HC and LEVEL SHALL hold, TICK SHALL stay 0, and HIT SHALL be ignored.
REQ-029 In PAUSED, PAUSE low SHALL return to RUN, and counting SHALL resume from the held CNT on the following edge.
REQ-030 GAME_OVER high in RUN or PAUSED SHALL move to IDLE with CNT<=0, TICK<=0 and LEVEL held for display.
REQ-031 Input priority SHALL be GAME_OVER > PAUSE > HIT/count; START outside IDLE SHALL be ignored.
REQ-032 In IDLE, TICK and LEVEL_UP SHALL be 0, and HIT and PAUSE SHALL be ignored.
REQ-033 START and PAUSE high together in IDLE SHALL go to RUN; PAUSED is entered on the next edge.

Reset
REQ-034 RESET low SHALL immediately, independent of clock, force STATE=IDLE, CNT=0, HC=0, LEVEL=0, TICK=0 and LEVEL_UP=0.
REQ-035 RESET asserted mid-game SHALL abort the game; after release the block SHALL wait in IDLE for START.
REQ-036 The block SHALL require no state initialisation other than RESET.

Verification (bench parameters LOAD0=3, LOAD1=2, LOAD2=1, LOAD3=0, HITS_PER_LEVEL=2)
REQ-037 Case: START pulse -> TICK high for one cycle on edge 4 after START, then every 4 cycles.
REQ-038 Case: two HITs in RUN -> LEVEL_UP pulse, LEVEL=1; current period completes, then TICK every 3 cycles.
REQ-039 Case: eight HITs -> LEVEL saturates at 3 with exactly three LEVEL_UP pulses; TICK then high continuously.
REQ-040 Case: PAUSE high for 10 cycles mid-period -> no TICK, CNT frozen, HITs ignored; after release the period completes with the remaining count.
REQ-041 Case: GAME_OVER together with PAUSE and HIT -> STATE=IDLE, TICK=0, LEVEL unchanged; the next START restores LEVEL=0.
REQ-042 Case: RESET pulsed low between clock edges during RUN -> all outputs 0 immediately; START is required to resume.
